// File: rtl/alu_input_pkg.sv
// Shared types and defaults for the ALU operand-entry sequencer.
package alu_input_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam int unsigned DEB_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/alu_input_seq_btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional debouncer, rising-edge pulse.
// Debouncer is built only when ALU_INPUT_SEQ_DEBOUNCE_EN is defined.
module btn_cond
  import alu_input_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("btn_cond: DEB_CYCLES must be at least 2");
  end

  logic       sync1;
  logic       sync2;
  logic [1:0] fill;
  logic       armed;
  logic       prev;
  logic       level;

  // Pulses are only armed once a genuine low has passed through the synchronizer,
  // so a button held across reset release stays silent until re-pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      fill  <= '0;
      armed <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      if (fill[1] && !sync2) armed <= 1'b1;
      prev  <= level;
    end
  end

`ifdef ALU_INPUT_SEQ_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          deb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      deb <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign level = deb;
`else
  assign level = sync2;
`endif

  assign pulse = armed & level & ~prev;

endmodule

// File: rtl/alu_input_seq.sv
// Operand/operation entry sequencer feeding an ALU from switches and two buttons.
// Optional debouncing via ALU_INPUT_SEQ_DEBOUNCE_EN.
module alu_input_seq
  import alu_input_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] data_sw,
  input  logic [3:0]   op_sw,
  input  logic         btn_next,
  input  logic         btn_clear,
  output logic [N-1:0] A_num,
  output logic [N-1:0] B_num,
  output logic [3:0]   operation,
  output logic         valid,
  output logic [1:0]   state_code
);

  if (N < 1 || N > 8) begin : g_bad_n
    $error("alu_input_seq: N must be in 1..8");
  end

  state_t state;
  logic   next_p;
  logic   clear_p;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .pulse (next_p)
  );

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clear),
    .pulse (clear_p)
  );

  // Clear takes priority over a simultaneous advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_A;
      A_num     <= '0;
      B_num     <= '0;
      operation <= '0;
      valid     <= 1'b0;
    end else if (clear_p) begin
      state     <= S_A;
      A_num     <= '0;
      B_num     <= '0;
      operation <= '0;
      valid     <= 1'b0;
    end else if (next_p) begin
      case (state)
        S_A: begin
          A_num <= data_sw;
          state <= S_B;
        end
        S_B: begin
          B_num <= data_sw;
          state <= S_OP;
        end
        S_OP: begin
          operation <= op_sw;
          valid     <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          valid <= 1'b0;
          state <= S_A;
        end
        default: state <= S_A;
      endcase
    end
  end

  assign state_code = state;

endmodule

// File: doc/alu_input_seq.md
ALU_INPUT_SEQ -- requirements
Module: alu_input_seq

Interface
REQ-001 SHALL have parameter N, default 4, operand width in bits; legal range 1..8.
REQ-002 SHALL have parameter DEB_CYCLES, default 16, button-stable cycles required by the debouncer; minimum 2.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_sw  input  N  raw operand switches, asynchronous to clk.
REQ-006 SHALL have port op_sw  input  4  raw operation-select switches, asynchronous to clk.
REQ-007 SHALL have port btn_next  input  1  raw active-high "capture/advance" push button.
REQ-008 SHALL have port btn_clear  input  1  raw active-high "abort entry" push button.
REQ-009 SHALL have port A_num  output  N  registered operand A, drives the ALU A_num input.
REQ-010 SHALL have port B_num  output  N  registered operand B, drives the ALU B_num input.
REQ-011 SHALL have port operation  output  4  registered operation code, drives the ALU operation input.
REQ-012 SHALL have port valid  output  1  high while A_num/B_num/operation form a complete entry.
REQ-013 SHALL have port state_code  output  2  current FSM state for LED display.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer followed by a rising-edge detector producing a one-cycle pulse (next_p, clear_p).
REQ-015 A button held high SHALL produce exactly one pulse; no further pulse until it returns low.
REQ-016 FSM states SHALL be S_A(00), S_B(01), S_OP(10), S_DONE(11); state_code equals the state encoding.
REQ-017 S_A + next_p: A_num <= data_sw, go to S_B.
REQ-018 S_B + next_p: B_num <= data_sw, go to S_OP.
REQ-019 S_OP + next_p: operation <= op_sw, valid <= 1, go to S_DONE.
REQ-020 S_DONE + next_p: valid <= 0, go to S_A; A_num/B_num/operation hold until overwritten.
REQ-021 Without a pulse, state and all outputs SHALL hold.
REQ-022 clear_p in any state: A_num, B_num, operation <= 0, valid <= 0, go to S_A.
REQ-023 clear_p and next_p in the same cycle: clear SHALL win; next ignored.
REQ-024 Register updates SHALL take effect on the clk edge at which the pulse is high; outputs visible the following cycle.
REQ-025 Switch values SHALL be sampled only at the capture edge; switch changes at other times have no effect.

Reset
REQ-026 rst_n low SHALL immediately force state S_A, A_num=0, B_num=0, operation=0, valid=0, synchronizer/debouncer registers=0, regardless of clk.
REQ-027 Reset asserted mid-entry SHALL discard partial entry; after release, first next_p captures A.
REQ-028 A button held high across reset release SHALL NOT generate a pulse until released and re-pressed.

Configuration
REQ-029 Macro ALU_INPUT_SEQ_DEBOUNCE_EN defined: each synchronized button SHALL be accepted as high/low only after DEB_CYCLES consecutive equal samples; edge detector operates on the debounced level.
REQ-030 Macro undefined: no debouncer; edge detector operates directly on synchronizer output; pulse 3 cycles after raw rise.

Structure
REQ-031 Package alu_input_pkg SHALL hold the state typedef (enum logic [1:0]) and the DEB_CYCLES default constant.
REQ-032 Sub-module btn_cond (synchronizer, optional debouncer, edge detector) SHALL be instantiated once per button.

Verification
REQ-033 No debounce: next with data_sw=1111, next with 0011, next with op_sw=0001 -> A_num=1111, B_num=0011, operation=0001, valid=1, state_code=11.
REQ-034 btn_next held 50 cycles in S_A with data_sw=0101 -> A_num=0101, state_code=01, no further advance.
REQ-035 In S_OP with A=0011, B=0001: clear and next rise same cycle -> all outputs 0, state_code=00, valid=0.
REQ-036 rst_n pulsed low mid-S_B -> outputs 0 asynchronously; after release, next with data_sw=0111 -> A_num=0111.
REQ-037 Debounce on, DEB_CYCLES=16: 10-cycle glitch on btn_next -> no advance; 20-cycle press -> exactly one advance.
REQ-038 In S_DONE, next -> valid=0, state_code=00, A_num/B_num/operation unchanged.
